// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe
// Normalize / round-to-nearest-even / pack stage for the FP MAC result.
// This is a 3-stage valid/ready pipeline:
//   S1 registers the operands together with the leading-one index.
//   S2 renormalizes the magnitude and forms fraction, guard, sticky and the corrected exponent.
//   S3 rounds and packs the IEEE-style word.
// The optional status flags (out_ovf, out_unf, out_inx) exist only when
// FP_NORM_STATUS_EN is defined. out_result is identical in both builds.
module fp_norm_round_pipe #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [ex_width+1:0]           in_exp,
    input  logic [3*sig_width+6:0]        in_mant,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef FP_NORM_STATUS_EN
    output logic                          out_ovf,
    output logic                          out_unf,
    output logic                          out_inx,
`endif
    output logic [ex_width+sig_width:0]   out_result
);

    localparam int W  = 3*sig_width + 7;   // magnitude width
    localparam int R  = 2*sig_width;       // bit position carrying weight 2^0
    localparam int LW = $clog2(W);         // leading-one index width
    localparam int EW = ex_width + 3;      // wide signed exponent, never wraps
    localparam int FW = sig_width + 1;     // fraction plus rounding carry
    localparam int RW = 1 + ex_width + sig_width;

    localparam logic signed [EW-1:0] EXP_INF = EW'((2**ex_width) - 1);

    // ------------------------------------------------------------------
    // Handshake: a stage loads when its downstream is empty or advancing
    // ------------------------------------------------------------------
    logic v1_reg, v2_reg, v3_reg;
    logic en1, en2, en3;

    assign en3      = !v3_reg | out_ready;
    assign en2      = !v2_reg | en3;
    assign en1      = !v1_reg | en2;
    assign in_ready = en1;

    // Valid bits advance with their stage enables; reset empties the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            if (en1) v1_reg <= in_valid;
            if (en2) v2_reg <= v1_reg;
            if (en3) v3_reg <= v2_reg;
        end
    end

    // ------------------------------------------------------------------
    // S1: leading-one detect on the incoming magnitude
    // ------------------------------------------------------------------
    logic [LW-1:0] lead_next;
    logic          zero_next;

    // Highest set bit wins; index is 0 for a zero magnitude (flagged separately)
    always_comb begin
        lead_next = '0;
        for (int i = 0; i < W; i++) begin
            if (in_mant[i]) lead_next = LW'(i);
        end
        zero_next = (in_mant == '0);
    end

    logic                 s1_sign_reg;
    logic [ex_width+1:0]  s1_exp_reg;
    logic [W-1:0]         s1_mant_reg;
    logic [LW-1:0]        s1_lead_reg;
    logic                 s1_zero_reg;

    // S1 data capture (no reset: qualified by v1_reg)
    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            s1_sign_reg <= in_sign;
            s1_exp_reg  <= in_exp;
            s1_mant_reg <= in_mant;
            s1_lead_reg <= lead_next;
            s1_zero_reg <= zero_next;
        end
    end

    // ------------------------------------------------------------------
    // S2: renormalize so the leading one sits at bit W-1 (then dropped)
    // ------------------------------------------------------------------
    logic [LW-1:0]          sh_amt;
    logic [W-2:0]           mant_norm;
    logic [sig_width-1:0]   frac_next;
    logic                   guard_next;
    logic                   sticky_next;
    logic [EW-1:0]          ep_next;

    // Shift, split into fraction/guard/sticky, and rebase the exponent to L
    always_comb begin
        sh_amt      = LW'(W-1) - s1_lead_reg;
        mant_norm   = (W-1)'(s1_mant_reg << sh_amt);
        frac_next   = mant_norm[W-2 -: sig_width];
        guard_next  = mant_norm[W-2-sig_width];
        sticky_next = |mant_norm[W-3-sig_width:0];
        ep_next     = {s1_exp_reg[ex_width+1], s1_exp_reg}
                      + EW'(s1_lead_reg) - EW'(R);
    end

    logic                   s2_sign_reg;
    logic                   s2_zero_reg;
    logic [sig_width-1:0]   s2_frac_reg;
    logic                   s2_guard_reg;
    logic                   s2_sticky_reg;
    logic [EW-1:0]          s2_ep_reg;

    // S2 data capture (no reset: qualified by v2_reg)
    always_ff @(posedge clk) begin
        if (en2 && v1_reg) begin
            s2_sign_reg   <= s1_sign_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_frac_reg   <= frac_next;
            s2_guard_reg  <= guard_next;
            s2_sticky_reg <= sticky_next;
            s2_ep_reg     <= ep_next;
        end
    end

    // ------------------------------------------------------------------
    // S3: round to nearest even, then pack with zero/inf/flush priority
    // ------------------------------------------------------------------
    logic                   round_up;
    logic [FW-1:0]          frac_sum;
    logic signed [EW-1:0]   ep_round;
    logic                   is_ovf;
    logic                   is_unf;
    logic [RW-1:0]          res_next;
`ifdef FP_NORM_STATUS_EN
    logic                   ovf_next;
    logic                   unf_next;
    logic                   inx_next;
`endif

    // Rounding carry bumps the exponent; over/underflow judged after rounding
    always_comb begin
        round_up = s2_guard_reg & (s2_sticky_reg | s2_frac_reg[0]);
        frac_sum = {1'b0, s2_frac_reg} + FW'(round_up);
        ep_round = s2_ep_reg + EW'(frac_sum[sig_width]);
        is_ovf   = (ep_round >= EXP_INF);
        is_unf   = ep_round[EW-1] | (ep_round == '0);

        res_next = {s2_sign_reg, ep_round[ex_width-1:0], frac_sum[sig_width-1:0]};
`ifdef FP_NORM_STATUS_EN
        ovf_next = 1'b0;
        unf_next = 1'b0;
        inx_next = s2_guard_reg | s2_sticky_reg;
`endif
        if (s2_zero_reg) begin
            res_next = {s2_sign_reg, {(RW-1){1'b0}}};
`ifdef FP_NORM_STATUS_EN
            inx_next = 1'b0;
`endif
        end else if (is_ovf) begin
            res_next = {s2_sign_reg, {ex_width{1'b1}}, {sig_width{1'b0}}};
`ifdef FP_NORM_STATUS_EN
            ovf_next = 1'b1;
            inx_next = 1'b1;
`endif
        end else if (is_unf) begin
            res_next = {s2_sign_reg, {(RW-1){1'b0}}};
`ifdef FP_NORM_STATUS_EN
            unf_next = 1'b1;
            inx_next = 1'b1;
`endif
        end
    end

    logic [RW-1:0] res_reg;

    // Output register; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg <= '0;
        end else if (en3 && v2_reg) begin
            res_reg <= res_next;
        end
    end

    assign out_valid  = v3_reg;
    assign out_result = v3_reg ? res_reg : '0;

`ifdef FP_NORM_STATUS_EN
    logic ovf_reg, unf_reg, inx_reg;

    // Status flags travel with the result word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            inx_reg <= 1'b0;
        end else if (en3 && v2_reg) begin
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
            inx_reg <= inx_next;
        end
    end

    assign out_ovf = v3_reg & ovf_reg;
    assign out_unf = v3_reg & unf_reg;
    assign out_inx = v3_reg & inx_reg;
`endif

endmodule
